cosim_commit_arbiter: RTL and testbench

- Sequences retired-instruction traffic from several harts into one single-lane co-simulation checker port.
- Each hart's core emits a commit bundle of up to COMMIT_WIDTH instructions plus an optional interrupt/exception record per cycle.
- The block buffers one bundle per hart, arbitrates round-robin between harts, and serializes each bundle into one record per out handshake.
- Sits between the cores' trace ports and the DPI-based cosim step/trap black box; guarantees program order per hart and emits a hart's trap only after that bundle's commits.

---
 rtl/cosim_commit_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_cosim_commit_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cosim_commit_arbiter.sv
// Round-robin arbiter that buffers one commit bundle per hart and serializes it,
// lane by lane and then the optional trap, onto a single cosim checker port.
module cosim_commit_arbiter #(
    parameter int NHARTS       = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int XLEN         = 64
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NHARTS-1:0]                    in_valid,
    output logic [NHARTS-1:0]                    in_ready,
    input  logic [NHARTS*COMMIT_WIDTH-1:0]       in_mask,
    input  logic [NHARTS*COMMIT_WIDTH*XLEN-1:0]  in_pc,
    input  logic [NHARTS*COMMIT_WIDTH*32-1:0]    in_inst,
    input  logic [NHARTS*COMMIT_WIDTH*XLEN-1:0]  in_wdata,
    input  logic [NHARTS*COMMIT_WIDTH*XLEN-1:0]  in_mstatus,
    input  logic [NHARTS*COMMIT_WIDTH-1:0]       in_check,
    input  logic [NHARTS-1:0]                    in_int_xcpt,
    input  logic [NHARTS*XLEN-1:0]               in_cause,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [31:0]                          out_hartid,
    output logic                                 out_is_trap,
    output logic [XLEN-1:0]                      out_pc,
    output logic [31:0]                          out_inst,
    output logic [XLEN-1:0]                      out_wdata,
    output logic [XLEN-1:0]                      out_mstatus,
    output logic [XLEN-1:0]                      out_cause,
    output logic                                 out_check,
    output logic [63:0]                          commit_count
);
    localparam int NL = NHARTS * COMMIT_WIDTH;
    localparam int HW = (NHARTS > 1) ? $clog2(NHARTS) : 1;
    localparam int LW = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;
    localparam int IW = (NL > 1) ? $clog2(NL) : 1;

    typedef enum logic [1:0] {IDLE, DRAIN, TRAP, RELEASE} state_t;

    state_t                  state;
    logic [HW-1:0]           grant, rr, pick_h, cand;
    logic                    pick_found;
    logic [NHARTS-1:0]       slot_full, slot_xcpt, take;
    logic [COMMIT_WIDTH-1:0] slot_mask [NHARTS];
    logic [XLEN-1:0]         slot_pc [NL], slot_wdata [NL], slot_mstatus [NL];
    logic [31:0]             slot_inst [NL];
    logic [NL-1:0]           slot_check;
    logic [XLEN-1:0]         slot_cause [NHARTS];
    logic [COMMIT_WIDTH-1:0] cur_mask, rem_mask;
    logic [LW-1:0]           cur_lane, next_lane;
    logic [IW-1:0]           ld_idx;
    logic                    hs, mask_upd;

    function automatic logic [LW-1:0] lowest(input logic [COMMIT_WIDTH-1:0] m);
        lowest = '0;
        for (int i = COMMIT_WIDTH - 1; i >= 0; i--)
            if (m[i]) lowest = LW'(i);
    endfunction

    assign in_ready  = ~slot_full;
    assign cur_mask  = slot_mask[grant];
    assign rem_mask  = cur_mask & (cur_mask - COMMIT_WIDTH'(1));
    assign cur_lane  = lowest(cur_mask);
    assign next_lane = lowest(rem_mask);
    // Before the first record is loaded the head lane is shown; afterwards the
    // record being replaced is the head, so the successor is loaded.
    assign ld_idx    = IW'(grant) * IW'(COMMIT_WIDTH) + IW'(out_valid ? next_lane : cur_lane);
    assign hs        = out_valid & out_ready;
    assign mask_upd  = (state == DRAIN) & hs;

    always_comb begin
        pick_found = 1'b0;
        pick_h     = '0;
        cand       = '0;
        for (int i = 0; i < NHARTS; i++) begin
            cand = HW'((int'(rr) + i) % NHARTS);
            if (!pick_found && slot_full[cand]) begin
                pick_found = 1'b1;
                pick_h     = cand;
            end
        end
    end

    for (genvar h = 0; h < NHARTS; h++) begin : g_slot
        assign take[h] = in_valid[h] & ~slot_full[h] &
                         ((|in_mask[h*COMMIT_WIDTH +: COMMIT_WIDTH]) | in_int_xcpt[h]);

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                slot_full[h] <= 1'b0;
                slot_xcpt[h] <= 1'b0;
                slot_mask[h] <= '0;
            end else if (take[h]) begin
                slot_full[h] <= 1'b1;
                slot_xcpt[h] <= in_int_xcpt[h];
                slot_mask[h] <= in_mask[h*COMMIT_WIDTH +: COMMIT_WIDTH];
            end else if (state == RELEASE && grant == HW'(h)) begin
                slot_full[h] <= 1'b0;
            end else if (mask_upd && grant == HW'(h)) begin
                slot_mask[h] <= rem_mask;
            end
        end

        // Payload needs no reset: it is only read while the slot is full.
        always_ff @(posedge clock) begin
            if (take[h]) slot_cause[h] <= in_cause[h*XLEN +: XLEN];
        end

        for (genvar l = 0; l < COMMIT_WIDTH; l++) begin : g_lane
            localparam int K = h * COMMIT_WIDTH + l;
            always_ff @(posedge clock) begin
                if (take[h]) begin
                    slot_pc[K]      <= in_pc[K*XLEN +: XLEN];
                    slot_inst[K]    <= in_inst[K*32 +: 32];
                    slot_wdata[K]   <= in_wdata[K*XLEN +: XLEN];
                    slot_mstatus[K] <= in_mstatus[K*XLEN +: XLEN];
                    slot_check[K]   <= in_check[K];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            grant        <= '0;
            rr           <= '0;
            commit_count <= '0;
            out_valid    <= 1'b0;
            out_hartid   <= '0;
            out_is_trap  <= 1'b0;
            out_pc       <= '0;
            out_inst     <= '0;
            out_wdata    <= '0;
            out_mstatus  <= '0;
            out_cause    <= '0;
            out_check    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pick_found) begin
                    grant <= pick_h;
                    state <= (|slot_mask[pick_h]) ? DRAIN : TRAP;
                end
                DRAIN: begin
                    if (hs) commit_count <= commit_count + 64'd1;
                    if (!out_valid || (hs && |rem_mask)) begin
                        out_valid   <= 1'b1;
                        out_hartid  <= 32'(grant);
                        out_is_trap <= 1'b0;
                        out_pc      <= slot_pc[ld_idx];
                        out_inst    <= slot_inst[ld_idx];
                        out_wdata   <= slot_wdata[ld_idx];
                        out_mstatus <= slot_mstatus[ld_idx];
                        out_check   <= slot_check[ld_idx];
                        out_cause   <= '0;
                    end else if (hs && slot_xcpt[grant]) begin
                        out_is_trap <= 1'b1;
                        out_cause   <= slot_cause[grant];
                        out_pc      <= '0;
                        out_inst    <= '0;
                        out_wdata   <= '0;
                        out_mstatus <= '0;
                        out_check   <= 1'b0;
                        state       <= TRAP;
                    end else if (hs) begin
                        out_valid   <= 1'b0;
                        out_pc      <= '0;
                        out_inst    <= '0;
                        out_wdata   <= '0;
                        out_mstatus <= '0;
                        out_check   <= 1'b0;
                        state       <= RELEASE;
                    end
                end
                TRAP: begin
                    if (!out_valid) begin
                        out_valid   <= 1'b1;
                        out_hartid  <= 32'(grant);
                        out_is_trap <= 1'b1;
                        out_cause   <= slot_cause[grant];
                        out_pc      <= '0;
                        out_inst    <= '0;
                        out_wdata   <= '0;
                        out_mstatus <= '0;
                        out_check   <= 1'b0;
                    end else if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_is_trap <= 1'b0;
                        out_cause   <= '0;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    rr    <= (grant == HW'(NHARTS - 1)) ? '0 : grant + HW'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cosim_commit_arbiter.sv
// Directed bench for cosim_commit_arbiter: reset, draining, traps, round-robin,
// back-pressure and asynchronous reset mid-bundle.
module tb_cosim_commit_arbiter;
    localparam int NH = 2;
    localparam int CW = 2;
    localparam int XL = 64;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NH-1:0]         in_valid, in_ready, in_int_xcpt;
    logic [NH*CW-1:0]      in_mask, in_check;
    logic [NH*CW*XL-1:0]   in_pc, in_wdata, in_mstatus;
    logic [NH*CW*32-1:0]   in_inst;
    logic [NH*XL-1:0]      in_cause;
    logic                  out_valid, out_ready, out_is_trap, out_check;
    logic [31:0]           out_hartid, out_inst;
    logic [XL-1:0]         out_pc, out_wdata, out_mstatus, out_cause;
    logic [63:0]           commit_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    cosim_commit_arbiter #(.NHARTS(NH), .COMMIT_WIDTH(CW), .XLEN(XL)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
        .in_pc(in_pc), .in_inst(in_inst), .in_wdata(in_wdata),
        .in_mstatus(in_mstatus), .in_check(in_check),
        .in_int_xcpt(in_int_xcpt), .in_cause(in_cause),
        .out_valid(out_valid), .out_ready(out_ready), .out_hartid(out_hartid),
        .out_is_trap(out_is_trap), .out_pc(out_pc), .out_inst(out_inst),
        .out_wdata(out_wdata), .out_mstatus(out_mstatus), .out_cause(out_cause),
        .out_check(out_check), .commit_count(commit_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lane payload is derived from the PC so every field is predictable.
    task automatic bundle(input int h, input logic v, input logic [1:0] m,
                          input logic [63:0] p0, input logic [63:0] p1,
                          input logic x, input logic [63:0] c);
        in_valid[h]              = v;
        in_mask[h*CW +: CW]      = m;
        in_check[h*CW +: CW]     = m;
        in_int_xcpt[h]           = x;
        in_cause[h*XL +: XL]     = c;
        in_pc[(h*CW)*XL +: XL]   = p0;
        in_pc[(h*CW+1)*XL +: XL] = p1;
        in_wdata[(h*CW)*XL +: XL]   = p0 + 64'd1;
        in_wdata[(h*CW+1)*XL +: XL] = p1 + 64'd1;
        in_inst[(h*CW)*32 +: 32]    = p0[31:0] ^ 32'h13;
        in_inst[(h*CW+1)*32 +: 32]  = p1[31:0] ^ 32'h13;
        in_mstatus[(h*CW)*XL +: XL]   = 64'ha0000_1800;
        in_mstatus[(h*CW+1)*XL +: XL] = 64'ha0000_1800;
    endtask

    initial begin
        logic [1:0]  took;
        int          sent [NH];
        int          got;
        logic [63:0] gh [6];
        logic [63:0] gp [6];

        reset = 1'b0; out_ready = 1'b1;
        in_valid = '0; in_mask = '0; in_check = '0; in_int_xcpt = '0; in_cause = '0;
        in_pc = '0; in_wdata = '0; in_mstatus = '0; in_inst = '0;
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd3);
        chk("rst_count", commit_count, 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        reset = 1'b1;
        repeat (10) tick();
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_in_ready", 64'(in_ready), 64'd3);
        chk("idle_count", commit_count, 64'd0);

        // Two-lane bundle on hart0
        bundle(0, 1'b1, 2'b11, 64'h8000_0000, 64'h8000_0004, 1'b0, 64'd0);
        tick();
        in_valid = '0;
        chk("h0_ready_low", 64'(in_ready), 64'd2);
        chk("h0_t1_valid", 64'(out_valid), 64'd0);
        tick();
        chk("h0_t2_valid", 64'(out_valid), 64'd0);
        tick();
        chk("h0_r0_valid", 64'(out_valid), 64'd1);
        chk("h0_r0_pc", out_pc, 64'h8000_0000);
        chk("h0_r0_hart", 64'(out_hartid), 64'd0);
        chk("h0_r0_trap", 64'(out_is_trap), 64'd0);
        chk("h0_r0_inst", 64'(out_inst), 64'h8000_0013);
        chk("h0_r0_wdata", out_wdata, 64'h8000_0001);
        chk("h0_r0_mstatus", out_mstatus, 64'ha0000_1800);
        chk("h0_r0_check", 64'(out_check), 64'd1);
        tick();
        chk("h0_r1_pc", out_pc, 64'h8000_0004);
        chk("h0_r1_count", commit_count, 64'd1);
        tick();
        chk("h0_done_valid", 64'(out_valid), 64'd0);
        chk("h0_done_count", commit_count, 64'd2);
        chk("h0_ready_still_low", 64'(in_ready), 64'd2);
        tick();
        chk("h0_ready_back", 64'(in_ready), 64'd3);

        // Hart1 lane1 only plus trap
        bundle(1, 1'b1, 2'b10, 64'h9000_0000, 64'h9000_0004, 1'b1, 64'h8000_0000_0000_0007);
        tick();
        in_valid = '0;
        tick(); tick();
        chk("h1_c_valid", 64'(out_valid), 64'd1);
        chk("h1_c_pc", out_pc, 64'h9000_0004);
        chk("h1_c_hart", 64'(out_hartid), 64'd1);
        chk("h1_c_trap", 64'(out_is_trap), 64'd0);
        tick();
        chk("h1_t_valid", 64'(out_valid), 64'd1);
        chk("h1_t_trap", 64'(out_is_trap), 64'd1);
        chk("h1_t_cause", out_cause, 64'h8000_0000_0000_0007);
        chk("h1_t_pc", out_pc, 64'd0);
        chk("h1_t_count", commit_count, 64'd3);
        tick();
        chk("h1_end_valid", 64'(out_valid), 64'd0);
        chk("h1_end_count", commit_count, 64'd3);
        tick();
        chk("h1_ready_back", 64'(in_ready), 64'd3);

        // Empty bundle without trap is dropped
        bundle(0, 1'b1, 2'b00, 64'h1, 64'h2, 1'b0, 64'd0);
        tick();
        in_valid = '0;
        chk("drop_ready", 64'(in_ready), 64'd3);
        tick(); tick();
        chk("drop_valid", 64'(out_valid), 64'd0);

        // Round-robin with both harts streaming three single-lane bundles
        sent[0] = 0; sent[1] = 0; got = 0;
        bundle(0, 1'b1, 2'b01, 64'h1000, 64'd0, 1'b0, 64'd0);
        bundle(1, 1'b1, 2'b01, 64'h2000, 64'd0, 1'b0, 64'd0);
        for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
            took = in_valid & in_ready;
            tick();
            for (int h = 0; h < NH; h++) begin
                if (took[h]) begin
                    sent[h]++;
                    if (sent[h] < 3)
                        bundle(h, 1'b1, 2'b01, 64'h1000 * (h + 1) + 64'(sent[h]), 64'd0, 1'b0, 64'd0);
                    else
                        in_valid[h] = 1'b0;
                end
            end
            if (out_valid) begin
                gh[got] = 64'(out_hartid);
                gp[got] = out_pc;
                got++;
            end
        end
        in_valid = '0;
        chk("rr_records", 64'(got), 64'd6);
        for (int i = 0; i < got; i++) begin
            chk($sformatf("rr_hart%0d", i), gh[i], 64'(i % 2));
            chk($sformatf("rr_pc%0d", i), gp[i], 64'h1000 * 64'((i % 2) + 1) + 64'(i / 2));
        end
        repeat (3) tick();
        chk("rr_count", commit_count, 64'd9);

        // Back-pressure mid-drain
        bundle(0, 1'b1, 2'b11, 64'hA0, 64'hA4, 1'b0, 64'd0);
        tick();
        in_valid = '0;
        tick(); tick();
        chk("bp_first_pc", out_pc, 64'hA0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_hold_valid%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp_hold_pc%0d", i), out_pc, 64'hA0);
            chk($sformatf("bp_hold_count%0d", i), commit_count, 64'd9);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_resume_pc", out_pc, 64'hA4);
        chk("bp_resume_count", commit_count, 64'd10);
        tick();
        chk("bp_end_valid", 64'(out_valid), 64'd0);
        chk("bp_end_count", commit_count, 64'd11);
        repeat (2) tick();

        // Asynchronous reset in the middle of a hart1 drain
        bundle(1, 1'b1, 2'b11, 64'hB0, 64'hB8, 1'b0, 64'd0);
        tick();
        in_valid = '0;
        tick(); tick();
        chk("ar_lane0", out_pc, 64'hB0);
        tick();
        chk("ar_lane1", out_pc, 64'hB8);
        chk("ar_count_pre", commit_count, 64'd12);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid_low", 64'(out_valid), 64'd0);
        chk("ar_ready", 64'(in_ready), 64'd3);
        chk("ar_count", commit_count, 64'd0);
        chk("ar_pc", out_pc, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        bundle(1, 1'b1, 2'b11, 64'hC0, 64'hC8, 1'b0, 64'd0);
        tick();
        in_valid = '0;
        tick(); tick();
        chk("ar_new_pc", out_pc, 64'hC0);
        chk("ar_new_hart", 64'(out_hartid), 64'd1);
        tick();
        chk("ar_new_pc1", out_pc, 64'hC8);
        chk("ar_new_count", commit_count, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
